// File: rtl/delay_pipe_pkg.sv
// Shared constants and helpers for the delay_pipe retiming block.
// Holds the select-width helper and the tap clamp used by the top level.
package delay_pipe_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 3;

  // Ceiling log2; callers pass DEPTH+1 so the result is always >= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Out-of-range selects map to the nearest real tap.
  function automatic int clamp_sel(input int sel, input int depth);
    if (sel < 1) begin
      return 1;
    end else if (sel > depth) begin
      return depth;
    end
    return sel;
  endfunction

endpackage

// File: rtl/delay_pipe_if.sv
// Data/control bundle of delay_pipe: upstream drives the word, tap select and
// pipe controls; the pipe returns the tapped word and the in-flight count.
interface delay_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) ();
  // No back-pressure: in_valid qualifies in_data on every edge with ce=1 and
  // flush=0; out_valid qualifies out_data, which is never masked.
  logic             ce;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] dly_sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] in_flight;

  modport master (
    output ce, flush, in_valid, in_data, dly_sel,
    input  out_valid, out_data, in_flight
  );

  modport slave (
    input  ce, flush, in_valid, in_data, dly_sel,
    output out_valid, out_data, in_flight
  );
endinterface

// File: rtl/delay_pipe_stage.sv
// One register stage of delay_pipe: a valid flag plus data word.
// Reset clears both, flush clears only the valid flag, ce advances.
module delay_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Flush leaves data in place so a flushed stage still shows its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_ce) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/delay_pipe.sv
// Run-time selectable delay line: DEPTH register stages with a tap mux and a
// count of valid words between the input and the selected tap.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               SEL_W     = clog2(DEPTH + 1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  delay_pipe_if.slave bus
);
  // Index 0 is the input port; 1..DEPTH are the stage outputs.
  logic [DEPTH:0]   w_v;
  logic [WIDTH-1:0] w_d [0:DEPTH];
  int               w_eff_sel;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic [SEL_W-1:0] w_in_flight;

  assign w_v[0] = bus.in_valid;
  assign w_d[0] = bus.in_data;

  generate
    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      delay_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (bus.ce),
        .i_flush (bus.flush),
        .i_valid (w_v[k-1]),
        .i_data  (w_d[k-1]),
        .o_valid (w_v[k]),
        .o_data  (w_d[k])
      );
    end
  endgenerate

  assign w_eff_sel = clamp_sel(int'(bus.dly_sel), DEPTH);

  // Tap mux and popcount read the flops directly; the tap follows dly_sel
  // immediately, so changing it re-exposes or skips words already in flight.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = w_d[1];
    w_in_flight = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == w_eff_sel) begin
        w_out_valid = w_v[k];
        w_out_data  = w_d[k];
      end
      if ((k <= w_eff_sel) && w_v[k]) begin
        w_in_flight = w_in_flight + SEL_W'(1);
      end
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.in_flight = w_in_flight;
endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe (DEPTH=3, WIDTH=8, SEL_W widened to 3 so an
// out-of-range select can be driven): vector table plus a reset-latency sequence.
module tb_delay_pipe;
  localparam int W = 8;
  localparam int S = 3;

  typedef struct {
    logic         rst;
    logic         ce;
    logic         flush;
    logic         iv;
    logic [W-1:0] id;
    logic [S-1:0] sel;
    logic         ev;
    logic [W-1:0] ed;
    logic [S-1:0] ef;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];
  logic [W+S:0] exp_q[$];

  delay_pipe_if #(.WIDTH(W), .SEL_W(S)) bus ();

  delay_pipe #(
    .WIDTH     (W),
    .DEPTH     (3),
    .SEL_W     (S),
    .RESET_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic f, input logic iv,
                     input logic [W-1:0] id, input logic [S-1:0] sel,
                     input logic ev, input logic [W-1:0] ed, input logic [S-1:0] ef);
    vec_t t;
    t.rst = r; t.ce = c; t.flush = f; t.iv = iv; t.id = id; t.sel = sel;
    t.ev = ev; t.ed = ed; t.ef = ef;
    vecs.push_back(t);
  endtask

  // Driver: present inputs, then sample one time unit after the edge.
  task automatic drive(input logic r, input logic c, input logic f, input logic iv,
                       input logic [W-1:0] id, input logic [S-1:0] sel);
    rst          = r;
    bus.ce       = c;
    bus.flush    = f;
    bus.in_valid = iv;
    bus.in_data  = id;
    bus.dly_sel  = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t         t;
    logic [W+S:0] e;
    int           lat;
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.ce = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.dly_sel = 3'd3;

    //  rst ce fl iv  data  sel   ev data  flight
    add(1, 0, 0, 0, 8'h00, 3'd3, 0, 8'h00, 3'd0);  // reset state
    add(0, 1, 0, 1, 8'hA1, 3'd3, 0, 8'h00, 3'd1);  // basic latency 3
    add(0, 1, 0, 1, 8'hB2, 3'd3, 0, 8'h00, 3'd2);
    add(0, 1, 0, 1, 8'hC3, 3'd3, 1, 8'hA1, 3'd3);
    add(0, 1, 0, 0, 8'h00, 3'd3, 1, 8'hB2, 3'd2);
    add(0, 1, 0, 0, 8'h00, 3'd3, 1, 8'hC3, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h55, 3'd1, 1, 8'h55, 3'd1);  // sel=1
    add(0, 1, 0, 0, 8'h00, 3'd1, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h66, 3'd0, 1, 8'h66, 3'd1);  // sel=0 clamps to 1
    add(0, 1, 0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0);
    add(0, 1, 0, 0, 8'h00, 3'd7, 1, 8'h66, 3'd1);  // sel=7 clamps to 3
    add(0, 1, 0, 0, 8'h00, 3'd7, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h77, 3'd7, 0, 8'h00, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd7, 0, 8'h00, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd7, 1, 8'h77, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd7, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h11, 3'd3, 0, 8'h00, 3'd1);  // stall
    add(0, 1, 0, 1, 8'h22, 3'd3, 0, 8'h00, 3'd2);
    add(0, 0, 0, 1, 8'hAA, 3'd3, 0, 8'h00, 3'd2);
    add(0, 0, 0, 0, 8'hBB, 3'd3, 0, 8'h00, 3'd2);
    add(0, 0, 0, 1, 8'hCC, 3'd3, 0, 8'h00, 3'd2);
    add(0, 0, 0, 1, 8'hDD, 3'd3, 0, 8'h00, 3'd2);
    add(0, 1, 0, 0, 8'h00, 3'd3, 1, 8'h11, 3'd2);
    add(0, 1, 0, 0, 8'h00, 3'd3, 1, 8'h22, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h31, 3'd3, 0, 8'h00, 3'd1);  // flush
    add(0, 1, 0, 1, 8'h32, 3'd3, 0, 8'h00, 3'd2);
    add(0, 1, 0, 1, 8'h33, 3'd3, 1, 8'h31, 3'd3);
    add(0, 0, 1, 1, 8'hEE, 3'd3, 0, 8'h31, 3'd0);
    add(0, 0, 0, 0, 8'h00, 3'd1, 0, 8'h33, 3'd0);  // data kept after flush
    add(0, 0, 0, 0, 8'h00, 3'd2, 0, 8'h32, 3'd0);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h32, 3'd0);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h33, 3'd0);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h41, 3'd3, 0, 8'h00, 3'd1);  // reset priority
    add(1, 1, 1, 1, 8'hFF, 3'd1, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h42, 3'd2, 0, 8'h00, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd2, 1, 8'h42, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd2, 0, 8'h00, 3'd0);
    add(0, 1, 0, 1, 8'h01, 3'd3, 0, 8'h00, 3'd1);  // tap change
    add(0, 1, 0, 1, 8'h02, 3'd3, 0, 8'h00, 3'd2);
    add(0, 1, 0, 1, 8'h03, 3'd3, 1, 8'h01, 3'd3);
    add(0, 1, 0, 1, 8'h04, 3'd1, 1, 8'h04, 3'd1);
    add(0, 1, 0, 1, 8'h05, 3'd1, 1, 8'h05, 3'd1);
    add(0, 1, 0, 1, 8'h06, 3'd1, 1, 8'h06, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd1, 0, 8'h00, 3'd0);
    add(0, 0, 0, 0, 8'h00, 3'd3, 1, 8'h05, 3'd2);  // raise re-exposes
    add(0, 1, 0, 0, 8'h00, 3'd3, 1, 8'h06, 3'd1);
    add(0, 1, 0, 0, 8'h00, 3'd3, 0, 8'h00, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      exp_q.push_back({t.ev, t.ed, t.ef});
      drive(t.rst, t.ce, t.flush, t.iv, t.id, t.sel);
      e = exp_q.pop_front();
      chk("out_valid", i, 32'(bus.out_valid), 32'(e[W+S]));
      chk("out_data", i, 32'(bus.out_data), 32'(e[W+S-1:S]));
      chk("in_flight", i, 32'(bus.in_flight), 32'(e[S-1:0]));
    end

    // Mid-stream reset: stale words are lost, next word emerges after 3 edges.
    drive(0, 1, 0, 1, 8'h10, 3'd3);
    drive(0, 1, 0, 1, 8'h20, 3'd3);
    drive(1, 1, 0, 1, 8'h30, 3'd3);
    chk("rst_valid", 100, 32'(bus.out_valid), 32'd0);
    chk("rst_flight", 100, 32'(bus.in_flight), 32'd0);
    chk("rst_data", 100, 32'(bus.out_data), 32'h00);
    drive(0, 1, 0, 1, 8'h5A, 3'd3);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      drive(0, 1, 0, 0, 8'h00, 3'd3);
      lat = lat + 1;
    end
    chk("post_rst_latency", 101, 32'(lat), 32'd3);
    chk("post_rst_data", 101, 32'(bus.out_data), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
